// File: rtl/led_drv_pkg.sv
// Shared constants and types for the command-driven LED PWM driver.
package led_drv_pkg;

   localparam int unsigned NUM_LEDS  = 4;
   localparam int unsigned LED_IDX_W = 2;

   typedef enum logic [1:0] {
      MODE_OFF       = 2'd0,
      MODE_ON        = 2'd1,
      MODE_BLINK     = 2'd2,
      MODE_ALT_BLINK = 2'd3
   } led_mode_e;

   localparam logic [LED_IDX_W-1:0] LED_RED    = 2'd0;
   localparam logic [LED_IDX_W-1:0] LED_ORANGE = 2'd1;
   localparam logic [LED_IDX_W-1:0] LED_GREEN  = 2'd2;
   localparam logic [LED_IDX_W-1:0] LED_BLUE   = 2'd3;

   typedef enum logic {
      IDLE    = 1'b0,
      PENDING = 1'b1
   } drv_state_e;

   // Level is carried separately because its width is a module parameter.
   typedef struct packed {
      logic [LED_IDX_W-1:0] led;
      led_mode_e            mode;
   } cmd_hdr_t;

   // Combine the PWM comparison with the blink phase according to the LED mode.
   function automatic logic mode_gate(input led_mode_e mode, input logic pwm_on,
                                      input logic phase);
      logic on;
      on = 1'b0;
      case (mode)
         MODE_OFF:       on = 1'b0;
         MODE_ON:        on = pwm_on;
         MODE_BLINK:     on = pwm_on & phase;
         MODE_ALT_BLINK: on = pwm_on & ~phase;
      endcase
      return on;
   endfunction

endpackage

// File: rtl/led_pwm_timebase.sv
// Prescaler, PWM counter and blink phase generator; frame_end is registered
// so that it is high exactly while the counters sit at the last frame clock.
module led_pwm_timebase #(
   parameter int unsigned PWM_BITS     = 8,
   parameter int unsigned PRESCALE     = 64,
   parameter int unsigned BLINK_FRAMES = 32
) (
   input  logic                clk,
   input  logic                rst_n,
   output logic [PWM_BITS-1:0] pwm_cnt,
   output logic                blink_phase,
   output logic                frame_end
);

   localparam int unsigned PRE_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
   localparam int unsigned BLK_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

   logic [PRE_W-1:0]    prescaler;
   logic [PRE_W-1:0]    prescaler_nxt;
   logic [PWM_BITS-1:0] pwm_nxt;
   logic [BLK_W-1:0]    blink_cnt;
   logic                tick;
   logic                frame_nxt;

   // Look one state ahead so frame_end lines up with the counter state it marks.
   always_comb begin
      tick          = (prescaler == PRE_W'(PRESCALE - 1));
      prescaler_nxt = tick ? '0 : prescaler + PRE_W'(1);
      pwm_nxt       = tick ? pwm_cnt + PWM_BITS'(1) : pwm_cnt;
      frame_nxt     = (prescaler_nxt == PRE_W'(PRESCALE - 1)) && (pwm_nxt == '1);
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         prescaler   <= '0;
         pwm_cnt     <= '0;
         blink_cnt   <= '0;
         blink_phase <= 1'b0;
         frame_end   <= 1'b0;
      end else begin
         prescaler <= prescaler_nxt;
         pwm_cnt   <= pwm_nxt;
         frame_end <= frame_nxt;
         if (frame_end) begin
            if (blink_cnt == BLK_W'(BLINK_FRAMES - 1)) begin
               blink_cnt   <= '0;
               blink_phase <= ~blink_phase;
            end else begin
               blink_cnt <= blink_cnt + BLK_W'(1);
            end
         end
      end
   end

endmodule

// File: rtl/led_pwm_driver.sv
// Command-driven four-LED PWM driver; updates take effect only at frame boundaries.
module led_pwm_driver
   import led_drv_pkg::*;
#(
   parameter int unsigned PWM_BITS        = 8,
   parameter int unsigned PRESCALE        = 64,
   parameter int unsigned BLINK_FRAMES    = 32,
   parameter int unsigned LED_ACTIVE_HIGH = 1
) (
   input  logic                 i_clk,
   input  logic                 i_rst_n,
   input  logic                 i_cmd_valid,
   output logic                 o_cmd_ready,
   input  logic [1:0]           i_cmd_led,
   input  logic [1:0]           i_cmd_mode,
   input  logic [PWM_BITS-1:0]  i_cmd_level,
   output logic                 o_frame_stb,
   output logic                 o_led_blue,
   output logic                 o_led_green,
   output logic                 o_led_orange,
   output logic                 o_led_red
);

   localparam logic PIN_INV = (LED_ACTIVE_HIGH == 0) ? 1'b1 : 1'b0;

   drv_state_e          state;
   cmd_hdr_t            shadow_hdr;
   logic [PWM_BITS-1:0] shadow_level;
   led_mode_e           mode_q  [NUM_LEDS];
   logic [PWM_BITS-1:0] level_q [NUM_LEDS];
   logic [NUM_LEDS-1:0] led_on_c;
   logic [NUM_LEDS-1:0] pins;
   logic [PWM_BITS-1:0] pwm_cnt;
   logic                blink_phase;
   logic                frame_end;

   led_pwm_timebase #(
      .PWM_BITS     (PWM_BITS),
      .PRESCALE     (PRESCALE),
      .BLINK_FRAMES (BLINK_FRAMES)
   ) u_timebase (
      .clk         (i_clk),
      .rst_n       (i_rst_n),
      .pwm_cnt     (pwm_cnt),
      .blink_phase (blink_phase),
      .frame_end   (frame_end)
   );

   always_comb begin
      led_on_c = '0;
      for (int unsigned i = 0; i < NUM_LEDS; i++) begin
         led_on_c[LED_IDX_W'(i)] = mode_gate(mode_q[LED_IDX_W'(i)],
                                             pwm_cnt < level_q[LED_IDX_W'(i)], blink_phase);
      end
   end

   // Command FSM, active LED registers and registered pins.
   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         state           <= IDLE;
         o_cmd_ready     <= 1'b0;
         shadow_hdr.led  <= LED_RED;
         shadow_hdr.mode <= MODE_OFF;
         shadow_level    <= '0;
         pins            <= {NUM_LEDS{PIN_INV}};
         for (int unsigned i = 0; i < NUM_LEDS; i++) begin
            mode_q[LED_IDX_W'(i)]  <= MODE_OFF;
            level_q[LED_IDX_W'(i)] <= '0;
         end
      end else begin
         pins <= led_on_c ^ {NUM_LEDS{PIN_INV}};
         case (state)
            IDLE: begin
               if (i_cmd_valid && o_cmd_ready) begin
                  shadow_hdr.led  <= i_cmd_led;
                  shadow_hdr.mode <= led_mode_e'(i_cmd_mode);
                  shadow_level    <= i_cmd_level;
                  o_cmd_ready     <= 1'b0;
                  state           <= PENDING;
               end else begin
                  o_cmd_ready <= 1'b1;
               end
            end
            PENDING: begin
               if (frame_end) begin
                  mode_q[shadow_hdr.led]  <= shadow_hdr.mode;
                  level_q[shadow_hdr.led] <= shadow_level;
                  o_cmd_ready             <= 1'b1;
                  state                   <= IDLE;
               end
            end
         endcase
      end
   end

   assign o_frame_stb  = frame_end;
   assign o_led_red    = pins[LED_RED];
   assign o_led_orange = pins[LED_ORANGE];
   assign o_led_green  = pins[LED_GREEN];
   assign o_led_blue   = pins[LED_BLUE];

endmodule

// File: tb/tb_led_pwm_driver.sv
// Directed bench for led_pwm_driver with a 32-clock frame (PWM_BITS=4, PRESCALE=2, BLINK_FRAMES=2).
module tb_led_pwm_driver;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       valid = 1'b0;
   logic       ready;
   logic [1:0] led = 2'd0;
   logic [1:0] mode = 2'd0;
   logic [3:0] level = 4'd0;
   logic       stb;
   logic       pin_b, pin_g, pin_o, pin_r;

   int unsigned n_checks = 0;
   int unsigned n_pass   = 0;
   int unsigned n_fail   = 0;

   always #5 clk = ~clk;

   led_pwm_driver #(
      .PWM_BITS        (4),
      .PRESCALE        (2),
      .BLINK_FRAMES    (2),
      .LED_ACTIVE_HIGH (1)
   ) dut (
      .i_clk        (clk),
      .i_rst_n      (rst_n),
      .i_cmd_valid  (valid),
      .o_cmd_ready  (ready),
      .i_cmd_led    (led),
      .i_cmd_mode   (mode),
      .i_cmd_level  (level),
      .o_frame_stb  (stb),
      .o_led_blue   (pin_b),
      .o_led_green  (pin_g),
      .o_led_orange (pin_o),
      .o_led_red    (pin_r)
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   // Step until o_frame_stb is seen; returns the number of steps taken.
   task automatic wait_frame(output int unsigned steps);
      steps = 0;
      while (stb !== 1'b1 && steps < 200) begin
         step();
         steps++;
      end
      if (stb !== 1'b1) check("frame_timeout", 32'(stb), 32'd1);
   endtask

   task automatic count_win(input int unsigned n, output int unsigned cr, output int unsigned co,
                            output int unsigned cg, output int unsigned cb,
                            output int unsigned cboth, output int unsigned crdy);
      cr = 0; co = 0; cg = 0; cb = 0; cboth = 0; crdy = 0;
      for (int i = 0; i < int'(n); i++) begin
         step();
         cr    += 32'(pin_r);
         co    += 32'(pin_o);
         cg    += 32'(pin_g);
         cb    += 32'(pin_b);
         cboth += 32'(pin_b & pin_g);
         crdy  += 32'(ready);
      end
   endtask

   // Issue one command and step past the frame_end that applies it.
   task automatic send_and_apply(input logic [1:0] l, input logic [1:0] m, input logic [3:0] lv);
      int unsigned w;
      w = 0;
      while (ready !== 1'b1 && w < 100) begin
         step();
         w++;
      end
      if (ready !== 1'b1) check("ready_timeout", 32'(ready), 32'd1);
      led = l; mode = m; level = lv; valid = 1'b1;
      step();
      valid = 1'b0;
      wait_frame(w);
      step();
   endtask

   initial begin
      int unsigned w;
      int unsigned cr, co, cg, cb, cboth, crdy;
      logic first_b;

      // Reset held with a command presented.
      valid = 1'b1; led = 2'd0; mode = 2'd1; level = 4'd15;
      repeat (5) begin
         step();
         check("rst_ready", 32'(ready), 32'd0);
         check("rst_pins", 32'({pin_b, pin_g, pin_o, pin_r}), 32'd0);
         check("rst_stb", 32'(stb), 32'd0);
      end
      valid = 1'b0;
      rst_n = 1'b1;
      step();
      check("ready_after_rst", 32'(ready), 32'd1);

      // Blue BLINK then green ALT_BLINK, both level 15.
      led = 2'd3; mode = 2'd2; level = 4'd15; valid = 1'b1;
      step();
      valid = 1'b0;
      check("blue_accept_ready", 32'(ready), 32'd0);
      wait_frame(w);
      check("blue_frame_wait", w, 32'd29);
      check("ready_low_at_frame", 32'(ready), 32'd0);
      step();
      check("ready_after_apply", 32'(ready), 32'd1);
      led = 2'd2; mode = 2'd3; level = 4'd15; valid = 1'b1;
      step();
      valid = 1'b0;
      first_b = pin_b;
      count_win(31, cr, co, cg, cb, cboth, crdy);
      check("blue_starts_dark", cb + 32'(first_b), 32'd0);
      check("reset_cmd_not_taken", cr, 32'd0);
      check("green_pending_ready", crdy, 32'd1);
      count_win(64, cr, co, cg, cb, cboth, crdy);
      check("blink_ph1_blue", cb, 32'd60);
      check("blink_ph1_green", cg, 32'd0);
      check("blink_ph1_both", cboth, 32'd0);
      count_win(64, cr, co, cg, cb, cboth, crdy);
      check("blink_ph0_blue", cb, 32'd0);
      check("blink_ph0_green", cg, 32'd60);
      check("blink_ph0_both", cboth, 32'd0);

      // Fresh reset, then red ON level 8.
      rst_n = 1'b0;
      step();
      step();
      check("rst2_pins", 32'({pin_b, pin_g, pin_o, pin_r}), 32'd0);
      check("rst2_ready", 32'(ready), 32'd0);
      rst_n = 1'b1;
      step();
      check("rst2_ready_after", 32'(ready), 32'd1);
      led = 2'd0; mode = 2'd1; level = 4'd8; valid = 1'b1;
      step();
      valid = 1'b0;
      check("red8_accept_ready", 32'(ready), 32'd0);
      wait_frame(w);
      check("red8_frame_wait", w, 32'd29);
      check("red8_ready_at_frame", 32'(ready), 32'd0);
      step();
      check("red8_ready_back", 32'(ready), 32'd1);
      check("red8_pin_stale", 32'(pin_r), 32'd0);
      step();
      check("red8_pin_rise", 32'(pin_r), 32'd1);
      count_win(31, cr, co, cg, cb, cboth, crdy);
      check("red8_duty_rest", cr, 32'd15);
      check("red8_others", co + cg + cb, 32'd0);

      send_and_apply(2'd0, 2'd1, 4'd0);
      count_win(32, cr, co, cg, cb, cboth, crdy);
      check("red0_duty", cr, 32'd0);

      send_and_apply(2'd0, 2'd1, 4'd15);
      count_win(32, cr, co, cg, cb, cboth, crdy);
      check("red15_duty", cr, 32'd30);

      // Command accepted in the frame_stb cycle, second command held during PENDING.
      wait_frame(w);
      led = 2'd0; mode = 2'd1; level = 4'd8; valid = 1'b1;
      step();
      check("stbcyc_accept_ready", 32'(ready), 32'd0);
      led = 2'd1; mode = 2'd1; level = 4'd4;
      count_win(32, cr, co, cg, cb, cboth, crdy);
      check("stbcyc_not_current", cr, 32'd30);
      check("held_not_merged", co, 32'd0);
      check("held_ready_count", crdy, 32'd1);
      step();
      valid = 1'b0;
      check("held_accepted", 32'(ready), 32'd0);
      wait_frame(w);
      check("held_frame_wait", w, 32'd30);
      step();
      count_win(32, cr, co, cg, cb, cboth, crdy);
      check("stbcyc_red_applied", cr, 32'd16);
      check("held_orange_applied", co, 32'd8);
      check("held_others", cg + cb, 32'd0);

      // Reset while a command is pending discards it.
      led = 2'd2; mode = 2'd1; level = 4'd15; valid = 1'b1;
      step();
      valid = 1'b0;
      check("pend_accept_ready", 32'(ready), 32'd0);
      repeat (3) step();
      rst_n = 1'b0;
      step();
      step();
      rst_n = 1'b1;
      step();
      check("pend_rst_ready", 32'(ready), 32'd1);
      count_win(64, cr, co, cg, cb, cboth, crdy);
      check("pend_discard_green", cg, 32'd0);
      check("pend_discard_others", cr + co + cb, 32'd0);
      send_and_apply(2'd0, 2'd1, 4'd8);
      count_win(32, cr, co, cg, cb, cboth, crdy);
      check("post_rst_red", cr, 32'd16);
      check("post_rst_green", cg, 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
